// File: rtl/vga_sig_gen.sv
// 640x480@60 VGA timing generator reading a 256x128 1-bit frame buffer.
// Each buffer pixel is shown as a 4x4 block; colour, HS and VS leave through one aligned register stage.
module vga_sig_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CONFIG_COLOURS,
  output logic [14:0] DPR_ADDR,
  input  logic        DPR_DATA,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [7:0]  VGA_COLOUR,
  output logic        FRAME_DONE
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [DW-1:0] d_q, d_d;
  logic [9:0]    hc_q, hc_d;
  logic [9:0]    vc_q, vc_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [7:0]    col_q, col_d;
  logic          fd_q, fd_d;
  logic          stb, vis, h_last, v_last;

  always_comb begin
    stb    = (d_q == D_LAST);
    h_last = (hc_q >= H_LAST);
    v_last = (vc_q >= V_LAST);
    vis    = (hc_q < H_VIS_C) && (vc_q < V_VIS_C);

    d_d   = (d_q >= D_LAST) ? '0 : d_q + 1'b1;
    hc_d  = hc_q;
    vc_d  = vc_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    col_d = col_q;
    fd_d  = 1'b0;

    // All outputs use the pre-increment counters, so they share one pixel of delay.
    if (stb) begin
      hc_d = h_last ? '0 : hc_q + 10'd1;
      if (h_last) begin
        vc_d = v_last ? '0 : vc_q + 10'd1;
      end
      col_d = vis ? (DPR_DATA ? CONFIG_COLOURS[15:8] : CONFIG_COLOURS[7:0]) : 8'h00;
      hs_d  = !((hc_q >= HS_BEG) && (hc_q <= HS_END));
      vs_d  = !((vc_q >= VS_BEG) && (vc_q <= VS_END));
      fd_d  = (hc_q == H_LAST) && (vc_q == V_LAST);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      d_q   <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      col_q <= 8'h00;
      fd_q  <= 1'b0;
    end else begin
      d_q   <= d_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      col_q <= col_d;
      fd_q  <= fd_d;
    end
  end

  // Address comes straight from the counters; the buffer answers one CLK later, well before the next strobe.
  assign DPR_ADDR   = {vc_q[8:2], hc_q[9:2]};
  assign VGA_HS     = hs_q;
  assign VGA_VS     = vs_q;
  assign VGA_COLOUR = col_q;
  assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_vga_sig_gen.sv
// Bench for vga_sig_gen with a shrunken raster so whole frames fit in a short run.
// Expected outputs are pushed per CLK from a time-based reference and popped by a separate monitor.
module tb_vga_sig_gen;

  localparam int CLK_DIV = 4;
  localparam int H_VIS = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
  localparam int V_VIS = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLKS = HT * VT * CLK_DIV;

  logic        clk;
  logic        rst;
  logic [15:0] cfg;
  logic [14:0] dpr_addr;
  logic        dpr_data = 1'b0;
  logic        vga_hs, vga_vs, frame_done;
  logic [7:0]  vga_colour;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  logic [15:0] cfg_s;
  logic [25:0] sb_q[$];

  vga_sig_gen #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .CONFIG_COLOURS(cfg),
    .DPR_ADDR(dpr_addr),
    .DPR_DATA(dpr_data),
    .VGA_HS(vga_hs),
    .VGA_VS(vga_vs),
    .VGA_COLOUR(vga_colour),
    .FRAME_DONE(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checkerboard of buffer pixels (X[0]^Y[0]) with one CLK read latency.
  always @(posedge clk) dpr_data <= dpr_addr[0] ^ dpr_addr[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  always @(posedge clk) begin : ref_model
    int k, q, ph, pv, ch, cv, a;
    logic hs_e, vs_e, fd_e;
    logic [7:0] col_e;
    if (rst) begin
      t = 0;
      sb_q.push_back({15'd0, 1'b1, 1'b1, 8'h00, 1'b0});
    end else begin
      t = t + 1;
      k = t / CLK_DIV;
      if (t % CLK_DIV == 0) cfg_s = cfg;
      ch = k % HT;
      cv = (k / HT) % VT;
      a  = ((cv >> 2) & 127) * 256 + ((ch >> 2) & 255);
      if (k == 0) begin
        hs_e = 1'b1; vs_e = 1'b1; col_e = 8'h00; fd_e = 1'b0;
      end else begin
        q  = k - 1;
        ph = q % HT;
        pv = (q / HT) % VT;
        hs_e = !(ph >= H_VIS + H_FP && ph < H_VIS + H_FP + H_SYNC);
        vs_e = !(pv >= V_VIS + V_FP && pv < V_VIS + V_FP + V_SYNC);
        if (ph < H_VIS && pv < V_VIS)
          col_e = ((((ph >> 2) ^ (pv >> 2)) & 1) != 0) ? cfg_s[15:8] : cfg_s[7:0];
        else
          col_e = 8'h00;
        fd_e = (t % CLK_DIV == 0) && (q % (HT * VT) == HT * VT - 1);
      end
      sb_q.push_back({a[14:0], hs_e, vs_e, col_e, fd_e});
    end
  end

  always @(negedge clk) begin : monitor
    logic [25:0] e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("outputs{addr,hs,vs,col,fd}",
          {6'd0, dpr_addr, vga_hs, vga_vs, vga_colour, frame_done}, {6'd0, e});
    end
  end

  int cyc = 0;
  int hs_fall = -1, vs_fall = -1, fd_last = -1;
  logic hs_p = 1'b1, vs_p = 1'b1;

  always @(negedge clk) begin : periods
    cyc++;
    if (rst) begin
      hs_fall = -1; vs_fall = -1; fd_last = -1;
      hs_p = 1'b1; vs_p = 1'b1;
    end else begin
      if (hs_p && !vga_hs) begin
        if (hs_fall >= 0) chk("hs_period", cyc - hs_fall, HT * CLK_DIV);
        hs_fall = cyc;
      end
      if (!hs_p && vga_hs && hs_fall >= 0) chk("hs_low_width", cyc - hs_fall, H_SYNC * CLK_DIV);
      if (vs_p && !vga_vs) begin
        if (vs_fall >= 0) chk("vs_period", cyc - vs_fall, FRAME_CLKS);
        vs_fall = cyc;
      end
      if (!vs_p && vga_vs && vs_fall >= 0) chk("vs_low_width", cyc - vs_fall, V_SYNC * HT * CLK_DIV);
      if (frame_done) begin
        if (fd_last >= 0) chk("frame_done_period", cyc - fd_last, FRAME_CLKS);
        fd_last = cyc;
      end
      hs_p = vga_hs;
      vs_p = vga_vs;
    end
  end

  task automatic wait_t(input int target);
    int g = 0;
    while (t < target && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (t < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_t: reached t=%0d required t=%0d", t, target);
    end
  endtask

  task automatic first_update(input string tag, input logic [7:0] bg);
    wait_t(3);
    chk({tag, "_col_before_stb"}, vga_colour, 8'h00);
    chk({tag, "_hs_before_stb"}, vga_hs, 1'b1);
    wait_t(4);
    chk({tag, "_col_first_stb"}, vga_colour, bg);
    chk({tag, "_hs_first_stb"}, vga_hs, 1'b1);
  endtask

  initial begin
    int g;
    rst = 1'b1;
    cfg = 16'hE01C;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    first_update("rel1", 8'h1C);

    // counters at HC=8, VC=4
    wait_t(929);
    chk("addr_hc8_vc4", dpr_addr, 15'h0102);

    // mid-pixel colour change: pixels 249 and 250 are both foreground
    wait_t(1001);
    #1 cfg = 16'h3CC3;
    chk("col_hold_after_change", vga_colour, 8'hE0);
    wait_t(1003);
    chk("col_hold_to_stb", vga_colour, 8'hE0);
    wait_t(1004);
    chk("col_new_at_stb", vga_colour, 8'h3C);

    // counters at last visible pixel HC=39, VC=11
    wait_t(2621);
    chk("addr_last_visible", dpr_addr, 15'h0209);

    wait_t(9000);

    g = 0;
    while (vga_hs !== 1'b0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("hs_low_before_reset", vga_hs, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst_hs", vga_hs, 1'b1);
    chk("rst_vs", vga_vs, 1'b1);
    chk("rst_colour", vga_colour, 8'h00);
    chk("rst_addr", dpr_addr, 15'h0000);
    chk("rst_frame_done", frame_done, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    first_update("rel2", 8'hC3);
    wait_t(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
